// File: rtl/irrigacao_pkg.sv
// Shared types and helpers for the irrigation controller: FSM states, mode codes,
// BCD mm:ss timer type and its conversion/decrement/display functions.
package irrigacao_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    IRRIGANDO = 2'd1,
    PAUSA     = 2'd2,
    ERRO      = 2'd3
  } estado_e;

  localparam logic MODO_GOTA = 1'b0;
  localparam logic MODO_ASP  = 1'b1;

  typedef struct packed {
    logic [3:0] min_d;
    logic [3:0] min_u;
    logic [3:0] seg_d;
    logic [3:0] seg_u;
  } tempo_bcd_t;

  localparam tempo_bcd_t TEMPO_ZERO = '0;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] bcd_para_7seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic tempo_bcd_t segundos_para_bcd(input int segundos);
    tempo_bcd_t r;
    int m;
    int s;
    m = segundos / 60;
    s = segundos % 60;
    r.min_d = 4'(m / 10);
    r.min_u = 4'(m % 10);
    r.seg_d = 4'(s / 10);
    r.seg_u = 4'(s % 10);
    return r;
  endfunction

  // One-second countdown with borrow; saturates at 00:00.
  function automatic tempo_bcd_t decrementa_bcd(input tempo_bcd_t t);
    tempo_bcd_t r;
    r = t;
    if (t != TEMPO_ZERO) begin
      if (t.seg_u != 4'd0) begin
        r.seg_u = t.seg_u - 4'd1;
      end else begin
        r.seg_u = 4'd9;
        if (t.seg_d != 4'd0) begin
          r.seg_d = t.seg_d - 4'd1;
        end else begin
          r.seg_d = 4'd5;
          if (t.min_u != 4'd0) begin
            r.min_u = t.min_u - 4'd1;
          end else begin
            r.min_u = 4'd9;
            r.min_d = t.min_d - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic nivel_valido(input logic [2:0] nivel);
    return (nivel == 3'b000) || (nivel == 3'b001) ||
           (nivel == 3'b011) || (nivel == 3'b111);
  endfunction

endpackage

// File: rtl/gerador_pulso.sv
// Free-running divider: counts 0..DIV-1 and wraps.
// pulso is combinational, high for the single cycle where the count is DIV-1.
module gerador_pulso #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  output logic pulso
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

  if (DIV < 2) begin : g_div_invalido
    $error("gerador_pulso: DIV must be >= 2");
  end

  logic [W-1:0] cont_q;
  logic [W-1:0] cont_d;

  always_comb begin
    cont_d = cont_q + W'(1);
    if (cont_q == ULTIMO) begin
      cont_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign pulso = (cont_q == ULTIMO);

endmodule

// File: rtl/controle_irrigacao.sv
// Irrigation controller: level-driven FSM, mm:ss countdown, fill-valve hysteresis, 4-digit mux display.
// All outputs registered (one cycle after the inputs are sampled) except umSegundo, which tracks the prescaler.
module controle_irrigacao
  import irrigacao_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int DUR_GOTA = 600,
  parameter int DUR_ASP  = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       umidadeAr,
  input  logic       umidadeSolo,
  input  logic       temperatura,
  input  logic [2:0] nivelDagua,
  output logic       valvulaEntrada,
  output logic       irrigando,
  output logic       modo,
  output logic       alarme,
  output logic       umSegundo,
  output logic [3:0] displayDigits,
  output logic [7:0] displaySegments
);

  if (DUR_GOTA < 1 || DUR_GOTA > 3599) begin : g_dur_gota_invalida
    $error("controle_irrigacao: DUR_GOTA must be in 1..3599");
  end
  if (DUR_ASP < 1 || DUR_ASP > 3599) begin : g_dur_asp_invalida
    $error("controle_irrigacao: DUR_ASP must be in 1..3599");
  end

  localparam tempo_bcd_t CARGA_GOTA = segundos_para_bcd(DUR_GOTA);
  localparam tempo_bcd_t CARGA_ASP  = segundos_para_bcd(DUR_ASP);
  localparam logic [7:0] SEG_TRACO  = 8'b1011_1111;

  logic tick;
  logic passo_scan;
  logic nivel_ok;

  gerador_pulso #(.DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .pulso (tick)
  );

  gerador_pulso #(.DIV(SCAN_DIV)) u_scan (
    .clock (clock),
    .reset (reset),
    .pulso (passo_scan)
  );

  estado_e    estado_q, estado_d;
  tempo_bcd_t tempo_q, tempo_d;
  logic       modo_q, modo_d;
  logic       irrigando_q, irrigando_d;
  logic       alarme_q, alarme_d;
  logic       valvula_q, valvula_d;
  logic       pisca_q, pisca_d;
  logic [1:0] scan_idx_q, scan_idx_d;
  logic [3:0] digitos_q, digitos_d;
  logic [7:0] segmentos_q, segmentos_d;
  logic [3:0] digito;
  logic       dp_aceso;

  assign nivel_ok = nivel_valido(nivelDagua);

  always_comb begin : proximo_estado
    estado_d = estado_q;
    tempo_d  = tempo_q;
    modo_d   = modo_q;
    if (!nivel_ok) begin
      estado_d = ERRO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          // The load wins over a coincident tick: nothing decrements in OCIOSO.
          if (umidadeSolo && nivelDagua[0]) begin
            estado_d = IRRIGANDO;
            modo_d   = (temperatura || !umidadeAr) ? MODO_ASP : MODO_GOTA;
            tempo_d  = (modo_d == MODO_ASP) ? CARGA_ASP : CARGA_GOTA;
          end
        end
        IRRIGANDO: begin
          if (nivelDagua == 3'b000) begin
            estado_d = PAUSA;
          end else if (tick) begin
            tempo_d = decrementa_bcd(tempo_q);
            if (tempo_d == TEMPO_ZERO) begin
              estado_d = OCIOSO;
            end
          end
        end
        PAUSA: begin
          if (nivelDagua[1]) begin
            estado_d = IRRIGANDO;
          end
        end
        ERRO: begin
          estado_d = OCIOSO;
          tempo_d  = TEMPO_ZERO;
        end
        default: begin
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  always_comb begin : saidas
    irrigando_d = (estado_d == IRRIGANDO);
    alarme_d    = (estado_d == ERRO);

    valvula_d = valvula_q;
    if (estado_d == ERRO) begin
      valvula_d = 1'b0;
    end else if (!nivelDagua[1]) begin
      valvula_d = 1'b1;
    end else if (nivelDagua[2]) begin
      valvula_d = 1'b0;
    end

    // Decimal point starts lit on entering PAUSA and flips on every tick there.
    pisca_d    = (estado_q == PAUSA) ? (pisca_q ^ tick) : 1'b1;
    scan_idx_d = passo_scan ? (scan_idx_q + 2'd1) : scan_idx_q;

    case (scan_idx_q)
      2'd0:    digito = tempo_q.seg_u;
      2'd1:    digito = tempo_q.seg_d;
      2'd2:    digito = tempo_q.min_u;
      default: digito = tempo_q.min_d;
    endcase
    if (estado_q == OCIOSO) begin
      digito = 4'd0;
    end

    dp_aceso    = (scan_idx_q == 2'd2) && ((estado_q != PAUSA) || pisca_q);
    digitos_d   = ~(4'b0001 << scan_idx_q);
    segmentos_d = {~dp_aceso, bcd_para_7seg(digito)};
    if (estado_q == ERRO) begin
      segmentos_d = SEG_TRACO;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      tempo_q     <= TEMPO_ZERO;
      modo_q      <= MODO_GOTA;
      irrigando_q <= 1'b0;
      alarme_q    <= 1'b0;
      valvula_q   <= 1'b0;
      pisca_q     <= 1'b1;
      scan_idx_q  <= 2'd0;
      digitos_q   <= 4'b1111;
      segmentos_q <= 8'b1111_1111;
    end else begin
      estado_q    <= estado_d;
      tempo_q     <= tempo_d;
      modo_q      <= modo_d;
      irrigando_q <= irrigando_d;
      alarme_q    <= alarme_d;
      valvula_q   <= valvula_d;
      pisca_q     <= pisca_d;
      scan_idx_q  <= scan_idx_d;
      digitos_q   <= digitos_d;
      segmentos_q <= segmentos_d;
    end
  end

  assign valvulaEntrada  = valvula_q;
  assign irrigando       = irrigando_q;
  assign modo            = modo_q;
  assign alarme          = alarme_q;
  assign umSegundo       = tick;
  assign displayDigits   = digitos_q;
  assign displaySegments = segmentos_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Bench for controle_irrigacao: directed scenarios plus random level/sensor traffic,
// every cycle compared against a seconds-based behavioural model.
module tb_controle_irrigacao;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int DUR_GOTA = 65;
  localparam int DUR_ASP  = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       umidadeAr;
  logic       umidadeSolo;
  logic       temperatura;
  logic [2:0] nivelDagua;
  logic       valvulaEntrada;
  logic       irrigando;
  logic       modo;
  logic       alarme;
  logic       umSegundo;
  logic [3:0] displayDigits;
  logic [7:0] displaySegments;

  controle_irrigacao #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .DUR_GOTA (DUR_GOTA),
    .DUR_ASP  (DUR_ASP)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .umidadeAr       (umidadeAr),
    .umidadeSolo     (umidadeSolo),
    .temperatura     (temperatura),
    .nivelDagua      (nivelDagua),
    .valvulaEntrada  (valvulaEntrada),
    .irrigando       (irrigando),
    .modo            (modo),
    .alarme          (alarme),
    .umSegundo       (umSegundo),
    .displayDigits   (displayDigits),
    .displaySegments (displaySegments)
  );

  always #5 clock = ~clock;

  int n_asserts = 0;
  int n_falhas  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_asserts++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  // Reference model: remaining time kept as plain seconds.
  typedef enum int {M_OCIOSO, M_IRRIG, M_PAUSA, M_ERRO} mst_e;
  mst_e       m_st;
  int         m_rem;
  int         m_tick;
  int         m_scp;
  int         m_scan;
  int         m_pausa_ticks;
  bit         m_modo;
  bit         m_valv;
  logic [3:0] m_digits;
  logic [7:0] m_segs;

  function automatic logic [6:0] padrao(input int d);
    logic [6:0] ativo;
    case (d)
      0: ativo = 7'h3F;
      1: ativo = 7'h06;
      2: ativo = 7'h5B;
      3: ativo = 7'h4F;
      4: ativo = 7'h66;
      5: ativo = 7'h6D;
      6: ativo = 7'h7D;
      7: ativo = 7'h07;
      8: ativo = 7'h7F;
      default: ativo = 7'h6F;
    endcase
    return ~ativo;
  endfunction

  function automatic logic [7:0] seg_esperado(input mst_e st, input int rem, input int scan, input int pticks);
    int v;
    int dig;
    bit dp;
    if (st == M_ERRO) return 8'b1011_1111;
    v = (st == M_OCIOSO) ? 0 : rem;
    case (scan)
      0: dig = (v % 60) % 10;
      1: dig = (v % 60) / 10;
      2: dig = (v / 60) % 10;
      default: dig = (v / 60) / 10;
    endcase
    dp = (scan == 2) && ((st != M_PAUSA) || (pticks % 2 == 0));
    return {~dp, padrao(dig)};
  endfunction

  task automatic modelo_passo();
    bit   tick;
    bit   passo;
    bit   ok;
    mst_e ns;
    if (reset) begin
      m_st = M_OCIOSO; m_rem = 0; m_tick = 0; m_scp = 0; m_scan = 0;
      m_pausa_ticks = 0; m_modo = 0; m_valv = 0;
      m_digits = 4'hF; m_segs = 8'hFF;
      return;
    end
    tick  = (m_tick == TICK_DIV - 1);
    passo = (m_scp == SCAN_DIV - 1);
    ok    = (nivelDagua == 3'b000) || (nivelDagua == 3'b001) ||
            (nivelDagua == 3'b011) || (nivelDagua == 3'b111);
    m_digits = ~(4'b0001 << m_scan);
    m_segs   = seg_esperado(m_st, m_rem, m_scan, m_pausa_ticks);
    ns = m_st;
    if (!ok) begin
      ns = M_ERRO;
    end else begin
      case (m_st)
        M_OCIOSO: if (umidadeSolo && nivelDagua[0]) begin
          ns     = M_IRRIG;
          m_modo = temperatura || !umidadeAr;
          m_rem  = m_modo ? DUR_ASP : DUR_GOTA;
        end
        M_IRRIG: begin
          if (nivelDagua == 3'b000) begin
            ns = M_PAUSA;
            m_pausa_ticks = 0;
          end else if (tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) ns = M_OCIOSO;
          end
        end
        M_PAUSA: begin
          if (tick) m_pausa_ticks++;
          if (nivelDagua[1]) ns = M_IRRIG;
        end
        default: begin
          ns    = M_OCIOSO;
          m_rem = 0;
        end
      endcase
    end
    m_st = ns;
    if (ns == M_ERRO) m_valv = 0;
    else if (!nivelDagua[1]) m_valv = 1;
    else if (nivelDagua[2]) m_valv = 0;
    m_tick = (m_tick + 1) % TICK_DIV;
    m_scp  = (m_scp + 1) % SCAN_DIV;
    if (passo) m_scan = (m_scan + 1) % 4;
  endtask

  task automatic compara();
    check_eq("umSegundo", 32'(umSegundo), 32'(m_tick == TICK_DIV - 1));
    check_eq("irrigando", 32'(irrigando), 32'(m_st == M_IRRIG));
    check_eq("alarme", 32'(alarme), 32'(m_st == M_ERRO));
    check_eq("modo", 32'(modo), 32'(m_modo));
    check_eq("valvulaEntrada", 32'(valvulaEntrada), 32'(m_valv));
    check_eq("displayDigits", 32'(displayDigits), 32'(m_digits));
    check_eq("displaySegments", 32'(displaySegments), 32'(m_segs));
  endtask

  // Called at a negedge with inputs already set for the coming posedge.
  task automatic ciclo();
    modelo_passo();
    @(negedge clock);
    compara();
  endtask

  task automatic iniciar(input logic temp, input logic ar);
    temperatura = temp;
    umidadeAr   = ar;
    umidadeSolo = 1'b1;
    ciclo();
    umidadeSolo = 1'b0;
  endtask

  // Counts ticks seen while irrigating; umidadeSolo wiggles to show it is ignored.
  task automatic conta_ticks(input string tag, input int esperado);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (irrigando !== 1'b1) break;
      if (umSegundo === 1'b1) cnt++;
      umidadeSolo = 1'($urandom_range(0, 1));
      ciclo();
    end
    umidadeSolo = 1'b0;
    check_eq(tag, 32'(cnt), 32'(esperado));
    check_eq({tag, "_fim"}, 32'(irrigando), 32'(0));
  endtask

  initial begin
    logic [3:0] seq[$];
    logic [3:0] ultimo;
    logic [2:0] nv[5];
    bit         ve[5];

    reset = 1'b1; umidadeAr = 1'b1; umidadeSolo = 1'b0; temperatura = 1'b0; nivelDagua = 3'b111;
    @(negedge clock);
    ciclo();
    check_eq("rst_digits", 32'(displayDigits), 32'h0000_000F);
    check_eq("rst_segments", 32'(displaySegments), 32'h0000_00FF);
    check_eq("rst_irrigando", 32'(irrigando), 32'(0));
    reset = 1'b0;
    repeat (5) ciclo();

    // Drip: 01:05, counts down through 00:59 to 00:00 over 65 ticks.
    iniciar(1'b0, 1'b1);
    check_eq("gota_modo", 32'(modo), 32'(0));
    check_eq("gota_inicio", 32'(irrigando), 32'(1));
    conta_ticks("gota_ticks", DUR_GOTA);

    // Sprinkler: hot weather selects mode 1 for 3 ticks.
    repeat (3) ciclo();
    iniciar(1'b1, 1'b1);
    check_eq("asp_modo", 32'(modo), 32'(1));
    conta_ticks("asp_ticks", DUR_ASP);

    // Dry air also selects sprinkler; tank empties at 00:02, refills, resumes.
    repeat (2) ciclo();
    iniciar(1'b0, 1'b0);
    check_eq("pausa_modo", 32'(modo), 32'(1));
    for (int i = 0; i < 50 && m_rem != 2; i++) ciclo();
    nivelDagua = 3'b000;
    ciclo();
    check_eq("pausa_entra", 32'(irrigando), 32'(0));
    repeat (5 * TICK_DIV) ciclo();
    check_eq("pausa_mantem", 32'(irrigando), 32'(0));
    check_eq("pausa_valvula", 32'(valvulaEntrada), 32'(1));
    nivelDagua = 3'b011;
    ciclo();
    check_eq("pausa_retoma", 32'(irrigando), 32'(1));
    conta_ticks("pausa_resto", 2);

    // Invalid level code mid-irrigation.
    nivelDagua = 3'b111;
    iniciar(1'b0, 1'b1);
    repeat (6) ciclo();
    nivelDagua = 3'b010;
    ciclo();
    check_eq("erro_alarme", 32'(alarme), 32'(1));
    check_eq("erro_irrigando", 32'(irrigando), 32'(0));
    check_eq("erro_valvula", 32'(valvulaEntrada), 32'(0));
    for (int i = 0; i < 8; i++) begin
      ciclo();
      check_eq("erro_segmentos", 32'(displaySegments), 32'h0000_00BF);
    end
    nivelDagua = 3'b111;
    ciclo();
    check_eq("erro_sai", 32'(alarme), 32'(0));
    repeat (4) ciclo();

    // Fill valve hysteresis while idle.
    nv[0] = 3'b000; nv[1] = 3'b011; nv[2] = 3'b111; nv[3] = 3'b011; nv[4] = 3'b001;
    ve[0] = 1'b1;   ve[1] = 1'b1;   ve[2] = 1'b0;   ve[3] = 1'b0;   ve[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nivelDagua = nv[k];
      ciclo();
      check_eq("valvula_hist", 32'(valvulaEntrada), 32'(ve[k]));
    end

    // Reset in the middle of a sprinkler run.
    nivelDagua = 3'b111;
    iniciar(1'b1, 1'b1);
    repeat (7) ciclo();
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    check_eq("rst2_irrigando", 32'(irrigando), 32'(0));
    check_eq("rst2_modo", 32'(modo), 32'(0));
    check_eq("rst2_alarme", 32'(alarme), 32'(0));
    check_eq("rst2_valvula", 32'(valvulaEntrada), 32'(0));
    check_eq("rst2_umSegundo", 32'(umSegundo), 32'(0));
    check_eq("rst2_digits", 32'(displayDigits), 32'h0000_000F);
    check_eq("rst2_segments", 32'(displaySegments), 32'h0000_00FF);
    ultimo = displayDigits;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      ciclo();
      if (displayDigits !== ultimo) seq.push_back(displayDigits);
      ultimo = displayDigits;
    end
    check_eq("scan_passos", 32'(seq.size()), 32'(4));
    for (int k = 0; k < 4 && k < seq.size(); k++) begin
      check_eq("scan_ordem", 32'(seq[k]), 32'(4'hF ^ (4'b0001 << k)));
    end

    // Random traffic, biased toward valid levels.
    for (int s = 0; s < 200; s++) begin
      int r;
      int dur;
      r = $urandom_range(0, 19);
      if (r < 8)       nivelDagua = 3'b111;
      else if (r < 11) nivelDagua = 3'b011;
      else if (r < 14) nivelDagua = 3'b001;
      else if (r < 17) nivelDagua = 3'b000;
      else if (r < 19) begin
        case ($urandom_range(0, 3))
          0: nivelDagua = 3'b010;
          1: nivelDagua = 3'b100;
          2: nivelDagua = 3'b101;
          default: nivelDagua = 3'b110;
        endcase
      end
      umidadeAr   = 1'($urandom_range(0, 1));
      umidadeSolo = 1'($urandom_range(0, 1));
      temperatura = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 49) == 0);
      dur = $urandom_range(1, 24);
      for (int k = 0; k < dur; k++) begin
        ciclo();
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_falhas);
    $finish;
  end

endmodule
